mult_div_unit: RTL
==================

# mult_div_unit

Parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core, sitting beside the ALU in EX. Decodes the SPECIAL-opcode HI/LO group: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. Multiply and divide run iteratively, one bit per cycle. A stall output holds the pipeline while a HI/LO-dependent instruction meets a busy unit.

## Interface
- WIDTH, 32: operand, HI and LO width; must be at least 4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- valid  in  1  EX holds a real instruction, not a bubble.
- opcode  in  6  EX instruction opcode.
- funct  in  6  EX instruction funct.
- rs_data  in  WIDTH  forwarded rs value (multiplicand / dividend / MTHI/MTLO source).
- rt_data  in  WIDTH  forwarded rt value (multiplier / divisor).
- alu_mux  out  2  EX result select: 00 ALU, 01 HI, 10 LO.
- result  out  WIDTH  HI for MFHI, LO for MFLO, else 0.
- hi, lo  out  WIDTH  architectural registers.
- busy  out  1  iteration in progress.
- stall  out  1  freeze IF/ID/EX this cycle.
- div_by_zero  out  1  one-cycle pulse.

## Operation
- Group hit: valid && opcode==0 && funct ∈ {16 MFHI, 17 MTHI, 18 MFLO, 19 MTLO, 24 MULT, 25 MULTU, 26 DIV, 27 DIVU}.
- stall = busy && group hit, combinational. Non-group instructions are never stalled.
- alu_mux and result decode combinationally from opcode and funct, whatever the state of valid.
  - funct 16 gives alu_mux 01 and result = hi.
  - funct 18 gives alu_mux 10 and result = lo.
  - Anything else gives alu_mux 00 and result 0.
- MTHI and MTLO write hi or lo from rs_data at the edge, only when group hit && !busy.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE to MUL or DIV on a multiply or divide with !busy.
  - On that transition, latch operand magnitudes. Signed ops negate negative operands; unsigned ops take operands raw.
  - Also latch the result sign flags and load the iteration counter with WIDTH.
- MUL performs shift-add over a 2·WIDTH accumulator.
- DIV performs restoring shift-subtract, producing a WIDTH quotient and WIDTH remainder.
- Counter decrements each cycle. At 0, the state goes to FIX.
- FIX applies sign correction and writes hi/lo, then returns to IDLE.
- Result rules:
  - MULT/MULTU: {hi, lo} = full 2·WIDTH product.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - Signed most-negative ÷ −1: lo = most-negative (wraps), hi = 0.
- Divisor 0 on DIV/DIVU: the op is accepted but no iteration runs.
  - busy stays 0 and hi/lo are unchanged.
  - div_by_zero pulses high for the cycle after the accepting edge.
- Reset (any state): FSM to IDLE, hi = lo = 0, busy = 0, div_by_zero = 0. Any in-flight operation is discarded.

## Timing
- Accept edge E0. busy is high from after E0 through the cycle before E(WIDTH+1), which is WIDTH+1 cycles.
- hi/lo take the new value at edge E(WIDTH+1). busy is low in the following cycle.
- An MFHI/MFLO stalled on busy releases in the first cycle busy=0 and reads the new value that same cycle.
- A multiply/divide arriving while busy stalls. It is accepted on the first edge with busy=0, so there is no back-to-back overlap.
- Mid-operation, rs_data/rt_data changes have no effect, because operands are latched at E0.
- MTHI/MTLO during busy stalls. It never overwrites a pending result.

## Structure
- Shared package or header `mips_defs`:
  - funct constants FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO, FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU.
  - OPCODE_SPECIAL.
  - alu_mux encodings MUX_ALU, MUX_HI, MUX_LO.
- FSM state encodings stay local.
- Sub-module `muldiv_decode`: combinational opcode/funct decode producing group hit, op class, signedness, alu_mux and the HI/LO write enables. Everything else stays in one module.

## Test plan
- Reset held 2 cycles, then released: hi = lo = 0, busy = 0, stall = 0, div_by_zero = 0.
- MULT, rs = 0xFFFFFFFD, rt = 7: busy for 33 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. MULTU, rs = rt = 0xFFFFFFFF: hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed and unsigned divide:
  - DIV, rs = 0xFFFFFFF9 (−7), rt = 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU, rs = 7, rt = 2: lo = 3, hi = 1.
  - DIV, rs = 0x80000000, rt = 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIV, rt = 0, with hi/lo preloaded 0x11111111 / 0x22222222: div_by_zero high 1 cycle, busy stays 0, hi/lo unchanged.
- MFLO issued 1 cycle after a MULT accept: stall high until busy falls. Then alu_mux = 10 and result equals the new lo. An ADD issued during busy is not stalled.
- reset asserted 10 cycles into a DIV: next cycle busy = 0, hi = lo = 0. A following MTHI with rs = 5 gives hi = 5 after one edge.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings used by the EX-stage HI/LO multiply/divide unit.
package mips_defs;

    localparam logic [5:0] OPCODE_SPECIAL = 6'd0;

    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MTHI  = 6'd17;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MTLO  = 6'd19;
    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIV   = 6'd26;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_HI  = 2'b01;
    localparam logic [1:0] MUX_LO  = 2'b10;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_MUL,
        OP_DIV,
        OP_MOVE
    } opClassT;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational decode of the SPECIAL-opcode HI/LO instruction group.
module muldiv_decode
    import mips_defs::*;
(
    input  logic       valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       groupHit,
    output opClassT    opClass,
    output logic       signedOp,
    output logic       hiWe,
    output logic       loWe,
    output logic [1:0] aluMux
);

    logic    special;
    opClassT functClass;

    assign special = (opcode == OPCODE_SPECIAL);

    always_comb begin
        functClass = OP_NONE;
        case (funct)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO: functClass = OP_MOVE;
            FUNCT_MULT, FUNCT_MULTU:                         functClass = OP_MUL;
            FUNCT_DIV, FUNCT_DIVU:                           functClass = OP_DIV;
            default:                                         functClass = OP_NONE;
        endcase
    end

    assign groupHit = valid && special && (functClass != OP_NONE);
    assign opClass  = groupHit ? functClass : OP_NONE;
    assign signedOp = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign hiWe     = groupHit && (funct == FUNCT_MTHI);
    assign loWe     = groupHit && (funct == FUNCT_MTLO);

    // Result select ignores valid so the forwarding mux settles early.
    always_comb begin
        aluMux = MUX_ALU;
        if (special && funct == FUNCT_MFHI)
            aluMux = MUX_HI;
        else if (special && funct == FUNCT_MFLO)
            aluMux = MUX_LO;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers, one bit per cycle.
module mult_div_unit
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [1:0]       alu_mux,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic isSigned);
        return (isSigned && v[WIDTH-1]) ? -v : v;
    endfunction

    stateT            state;
    logic [CW-1:0]    count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] opB;
    logic             negLo;
    logic             negHi;
    logic             fixDiv;

    logic             groupHit;
    opClassT          opClass;
    logic             signedOp;
    logic             hiWe;
    logic             loWe;

    muldiv_decode uDecode (
        .valid    (valid),
        .opcode   (opcode),
        .funct    (funct),
        .groupHit (groupHit),
        .opClass  (opClass),
        .signedOp (signedOp),
        .hiWe     (hiWe),
        .loWe     (loWe),
        .aluMux   (alu_mux)
    );

    logic             idle;
    logic             startMul;
    logic             startDiv;
    logic             divZero;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    assign idle     = (state == IDLE);
    assign divZero  = (rt_data == '0);
    assign startMul = idle && opClass == OP_MUL;
    assign startDiv = idle && opClass == OP_DIV && !divZero;
    assign magA     = magnitude(rs_data, signedOp);
    assign magB     = magnitude(rt_data, signedOp);

    assign busy   = !idle;
    assign stall  = busy && groupHit;
    assign result = (alu_mux == MUX_HI) ? hi : (alu_mux == MUX_LO) ? lo : '0;

    // Per-iteration step: shift-add for multiply, restoring shift-subtract for divide.
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH+1:0]   divTrial;

    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opB : '0)};
    assign divShift = {remReg, acc[WIDTH-1]};
    assign divTrial = {1'b0, divShift} - {2'b00, opB};

    logic [2*WIDTH-1:0] mulFinal;
    logic [WIDTH-1:0]   quoFinal;
    logic [WIDTH-1:0]   remFinal;

    assign mulFinal = negLo ? -acc : acc;
    assign quoFinal = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remFinal = negHi ? -remReg : remReg;

    always_ff @(posedge clk) begin
        if (startMul) begin
            acc    <= {{WIDTH{1'b0}}, magB};
            opB    <= magA;
            negLo  <= signedOp && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            negHi  <= 1'b0;
            fixDiv <= 1'b0;
        end else if (startDiv) begin
            acc    <= {{WIDTH{1'b0}}, magA};
            remReg <= '0;
            opB    <= magB;
            negLo  <= signedOp && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            negHi  <= signedOp && rs_data[WIDTH-1];
            fixDiv <= 1'b1;
        end else if (state == MUL) begin
            acc <= {mulSum, acc[WIDTH-1:1]};
        end else if (state == DIV) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], !divTrial[WIDTH+1]};
            remReg         <= divTrial[WIDTH+1] ? divShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hiWe) hi <= rs_data;
                    if (loWe) lo <= rs_data;
                    if (startMul) begin
                        state <= MUL;
                        count <= CW'(WIDTH);
                    end else if (startDiv) begin
                        state <= DIV;
                        count <= CW'(WIDTH);
                    end else if (opClass == OP_DIV) begin
                        div_by_zero <= 1'b1;
                    end
                end
                MUL, DIV: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (fixDiv) {hi, lo} <= {remFinal, quoFinal};
                    else        {hi, lo} <= mulFinal;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
